// File: rtl/delta_pkg.sv
// Shared types and helpers for the delta integrator: FSM state and signed range bounds.
package delta_pkg;

    typedef enum logic [0:0] {
        IDLE,
        RUN
    } state_t;

    // Largest and smallest values representable in an n-bit two's complement sample.
    function automatic int smax(input int n);
        return (1 << (n - 1)) - 1;
    endfunction

    function automatic int smin(input int n);
        return -(1 << (n - 1));
    endfunction

endpackage

// File: rtl/delta_integrator_if.sv
// Valid/ready stream bundle: difference words in, reconstructed samples out.
interface delta_integrator_if #(
    parameter int N = 8
);
    logic signed [N+1:0] diff_in;
    logic                first_in;
    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] sample_out;
    logic                out_valid;
    logic                out_ready;
    logic                sat_out;

    modport master (
        output diff_in, first_in, in_valid, out_ready,
        input  in_ready, sample_out, out_valid, sat_out
    );

    modport slave (
        input  diff_in, first_in, in_valid, out_ready,
        output in_ready, sample_out, out_valid, sat_out
    );
endinterface

// File: rtl/delta_range_reduce.sv
// Folds an (N+3)-bit signed sum into N bits: clamps when DELTA_INTEGRATOR_SAT_EN is
// defined, otherwise wraps modulo 2^N with the saturation flag held low.
module delta_range_reduce
    import delta_pkg::*;
#(
    parameter int N = 8
) (
    input  logic signed [N+2:0] value,
    output logic signed [N-1:0] reduced,
    output logic                sat
);

`ifdef DELTA_INTEGRATOR_SAT_EN
    localparam logic signed [N+2:0] SMAX = (N+3)'(smax(N));
    localparam logic signed [N+2:0] SMIN = (N+3)'(smin(N));

    always_comb begin
        reduced = value[N-1:0];
        sat     = 1'b0;
        if (value > SMAX) begin
            reduced = SMAX[N-1:0];
            sat     = 1'b1;
        end else if (value < SMIN) begin
            reduced = SMIN[N-1:0];
            sat     = 1'b1;
        end
    end
`else
    // Wrapping discards the guard bits entirely.
    logic unused_guard;
    assign unused_guard = ^value[N+2:N];
    assign reduced      = value[N-1:0];
    assign sat          = 1'b0;
`endif

endmodule

// File: rtl/delta_integrator.sv
// Rebuilds signed samples from a seeded stream of differences with one registered
// output stage. Define DELTA_INTEGRATOR_SAT_EN to clamp instead of wrap.
module delta_integrator
    import delta_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    delta_integrator_if.slave bus,
    output logic              err,
    output logic [CNT_W-1:0]  sample_cnt
);

    state_t              state;
    logic signed [N-1:0] acc;
    logic signed [N-1:0] sample_q;
    logic signed [N-1:0] reduced;
    logic                out_valid_q;
    logic                sat_q;
    logic                sat_next;
    logic                accept;
    logic                load;
    logic signed [N+2:0] acc_ext;
    logic signed [N+2:0] diff_ext;
    logic signed [N+2:0] next_val;

    assign bus.in_ready   = !out_valid_q || bus.out_ready;
    assign bus.sample_out = sample_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.sat_out    = sat_q;

    // Differences arriving before any seed are rejected and flagged instead of loaded.
    assign accept   = bus.in_valid && bus.in_ready;
    assign load     = accept && (bus.first_in || state == RUN);
    assign acc_ext  = {{3{acc[N-1]}}, acc};
    assign diff_ext = {bus.diff_in[N+1], bus.diff_in};
    assign next_val = bus.first_in ? diff_ext : acc_ext + diff_ext;

    delta_range_reduce #(.N(N)) u_range_reduce (
        .value   (next_val),
        .reduced (reduced),
        .sat     (sat_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            sample_q    <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            err         <= 1'b0;
        end else if (clr) begin
            state       <= IDLE;
            acc         <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept && !load) begin
                err <= 1'b1;
            end
            if (load) begin
                state       <= RUN;
                acc         <= reduced;
                sample_q    <= reduced;
                sat_q       <= sat_next;
                out_valid_q <= 1'b1;
            end
        end
    end

    // A delivery seen by downstream is counted even if clr drops the stage on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
        end else if (out_valid_q && bus.out_ready) begin
            sample_cnt <= sample_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_delta_integrator.sv
// Self-checking bench for delta_integrator (N=8, narrow counter to reach wrap quickly).
// Expected samples follow DELTA_INTEGRATOR_SAT_EN when it is defined for the build.
module tb_delta_integrator;
    import delta_pkg::*;

    localparam int N     = 8;
    localparam int CNT_W = 4;

`ifdef DELTA_INTEGRATOR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic first;
        int   diff;
        int   exp_sample;
        logic exp_sat;
    } vec_t;

    typedef struct {
        int   sample;
        logic sat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic             err;
    logic [CNT_W-1:0] sample_cnt;

    int     checks  = 0;
    int     errors  = 0;
    int     exp_cnt = 0;
    exp_t   sb[$];
    exp_t   mon_e;
    vec_t   tbl[11];
    longint t0;
    longint t1;

    delta_integrator_if #(.N(N)) bus ();

    delta_integrator #(.N(N), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .bus        (bus),
        .err        (err),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushExpected(input int sample, input logic sat);
        exp_t e;
        e.sample = sample;
        e.sat    = sat;
        sb.push_back(e);
    endtask

    // Presents one word and waits (bounded) until the DUT takes it.
    task automatic applyStimulus(input logic first, input int diff, input logic expect_out,
                                 input int exp_sample, input logic exp_sat);
        int budget;
        @(posedge clk);
        #1;
        bus.first_in = first;
        bus.diff_in  = (N+2)'(diff);
        bus.in_valid = 1'b1;
        for (budget = 0; budget < 20; budget++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        if (budget == 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 for 20 cycles, expected 1");
        end else if (expect_out) begin
            pushExpected(exp_sample, exp_sat);
        end
    endtask

    task automatic releaseInput();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.first_in = 1'b0;
    endtask

    task automatic pulseClear();
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    // Scoreboard: every delivered sample must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got sample %0d, expected no output",
                         int'(bus.sample_out));
            end else begin
                mon_e = sb.pop_front();
                checkOutput("sample_out", int'(bus.sample_out), mon_e.sample);
                checkOutput("sat_out", int'(bus.sat_out), int'(mon_e.sat));
            end
            exp_cnt++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tbl[0]  = '{1'b1,   10,   10,                  1'b0};
        tbl[1]  = '{1'b0,    5,   15,                  1'b0};
        tbl[2]  = '{1'b0,   -3,   12,                  1'b0};
        tbl[3]  = '{1'b1,  120,  120,                  1'b0};
        tbl[4]  = '{1'b0,   20,  SAT ?  127 : -116,    SAT};
        tbl[5]  = '{1'b1, -128, -128,                  1'b0};
        tbl[6]  = '{1'b0,   -1,  SAT ? -128 :  127,    SAT};
        tbl[7]  = '{1'b1,  300,  SAT ?  127 :   44,    SAT};
        tbl[8]  = '{1'b0,   -1,  SAT ?  126 :   43,    1'b0};
        tbl[9]  = '{1'b0,  200,  SAT ?  127 :  -13,    SAT};
        tbl[10] = '{1'b1, -300,  SAT ? -128 :  -44,    SAT};

        rst_n         = 1'b0;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.first_in  = 1'b0;
        bus.diff_in   = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        checkOutput("reset_out_valid", int'(bus.out_valid), 0);
        checkOutput("reset_sample_out", int'(bus.sample_out), 0);
        checkOutput("reset_sat_out", int'(bus.sat_out), 0);
        checkOutput("reset_err", int'(err), 0);
        checkOutput("reset_sample_cnt", int'(sample_cnt), 0);
        checkOutput("reset_in_ready", int'(bus.in_ready), 1);
        rst_n = 1'b1;

        $display("[TB] basic seed/add sequence");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(tbl[i].first, tbl[i].diff, 1'b1, tbl[i].exp_sample, tbl[i].exp_sat);
        end
        releaseInput();
        repeat (3) @(negedge clk);
        checkOutput("sample_cnt_after_three", int'(sample_cnt), 3);

        $display("[TB] range reduction vectors");
        for (int i = 3; i < 11; i++) begin
            applyStimulus(tbl[i].first, tbl[i].diff, 1'b1, tbl[i].exp_sample, tbl[i].exp_sat);
        end
        releaseInput();
        repeat (3) @(negedge clk);
        checkOutput("sample_cnt_after_table", int'(sample_cnt), exp_cnt % (1 << CNT_W));
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("[TB] difference before seed");
        pulseClear();
        @(negedge clk);
        checkOutput("err_after_clr", int'(err), 0);
        applyStimulus(1'b0, 7, 1'b0, 0, 1'b0);
        releaseInput();
        repeat (3) @(negedge clk);
        checkOutput("idle_diff_err", int'(err), 1);
        checkOutput("idle_diff_no_output", int'(bus.out_valid), 0);
        applyStimulus(1'b1, 5, 1'b1, 5, 1'b0);
        releaseInput();
        repeat (3) @(negedge clk);
        checkOutput("err_sticky", int'(err), 1);
        pulseClear();
        @(negedge clk);
        checkOutput("err_cleared", int'(err), 0);
        applyStimulus(1'b1, 5, 1'b1, 5, 1'b0);
        releaseInput();
        repeat (2) @(negedge clk);

        $display("[TB] backpressure hold");
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 50, 1'b1, 50, 1'b0);
        @(posedge clk);
        #1;
        bus.first_in = 1'b0;
        bus.diff_in  = (N+2)'(1);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall_in_ready", int'(bus.in_ready), 0);
            checkOutput("stall_out_valid", int'(bus.out_valid), 1);
            checkOutput("stall_sample_held", int'(bus.sample_out), 50);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        pushExpected(51, 1'b0);
        @(negedge clk);
        checkOutput("release_in_ready", int'(bus.in_ready), 1);
        releaseInput();
        repeat (3) @(negedge clk);
        checkOutput("stall_no_loss", sb.size(), 0);

        $display("[TB] sustained throughput and counter wrap");
        t0 = $time;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, i, 1'b1, i, 1'b0);
        end
        t1 = $time;
        checkOutput("twenty_words_time", int'(t1 - t0), 200);
        releaseInput();
        repeat (3) @(negedge clk);
        checkOutput("sample_cnt_wrapped", int'(sample_cnt), exp_cnt % (1 << CNT_W));

        $display("[TB] clear beats accept");
        @(posedge clk);
        #1;
        clr          = 1'b1;
        bus.in_valid = 1'b1;
        bus.first_in = 1'b0;
        bus.diff_in  = (N+2)'(3);
        @(posedge clk);
        #1;
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("clr_no_output", int'(bus.out_valid), 0);
        checkOutput("clr_state_idle", int'(dut.state), int'(IDLE));
        checkOutput("clr_acc_zero", int'(dut.acc), 0);
        applyStimulus(1'b0, 2, 1'b0, 0, 1'b0);
        releaseInput();
        repeat (2) @(negedge clk);
        checkOutput("clr_then_diff_err", int'(err), 1);

        $display("[TB] asynchronous reset mid-stream");
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 9, 1'b0, 0, 1'b0);
        releaseInput();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_out_valid", int'(bus.out_valid), 0);
        checkOutput("async_sample_out", int'(bus.sample_out), 0);
        checkOutput("async_err", int'(err), 0);
        checkOutput("async_sample_cnt", int'(sample_cnt), 0);
        checkOutput("async_state_idle", int'(dut.state), int'(IDLE));
        sb.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, -7, 1'b1, -7, 1'b0);
        releaseInput();
        repeat (3) @(negedge clk);
        checkOutput("post_reset_cnt", int'(sample_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
